signed_digits_7seg_scan: RTL

//  Downstream display stage for the signed 8-bit-to-digits converter. Latches sign/hundreds/tens/units
//  on a load strobe and time-multiplexes them onto a 4-digit common-anode 7-segment display.

---
 rtl/seg7_pkg.sv | 38 +++
 rtl/bcd_to_seg7.sv | 33 +++
 rtl/signed_digits_7seg_scan.sv | 131 +++++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// Shared encodings for the signed-digit 7-segment scan block: scan index,
// active-high segment patterns, and the latched display record.
package seg7_pkg;

  // Scan position; the value doubles as the anode bit number.
  typedef enum logic [1:0] {
    IDX_UNITS    = 2'd0,
    IDX_TENS     = 2'd1,
    IDX_HUNDREDS = 2'd2,
    IDX_SIGN     = 2'd3
  } idx_e;

  localparam int NUM_DIGITS = 3;  // numeric lanes: units, tens, hundreds
  localparam int BCD_W      = 4;
  localparam int SEG_W      = 7;
  localparam int NUM_AN     = 4;

  // Active-high patterns, bit order {g,f,e,d,c,b,a}.
  localparam logic [SEG_W-1:0] SEG_0     = 7'b0111111;
  localparam logic [SEG_W-1:0] SEG_1     = 7'b0000110;
  localparam logic [SEG_W-1:0] SEG_2     = 7'b1011011;
  localparam logic [SEG_W-1:0] SEG_3     = 7'b1001111;
  localparam logic [SEG_W-1:0] SEG_4     = 7'b1100110;
  localparam logic [SEG_W-1:0] SEG_5     = 7'b1101101;
  localparam logic [SEG_W-1:0] SEG_6     = 7'b1111101;
  localparam logic [SEG_W-1:0] SEG_7     = 7'b0000111;
  localparam logic [SEG_W-1:0] SEG_8     = 7'b1111111;
  localparam logic [SEG_W-1:0] SEG_9     = 7'b1101111;
  localparam logic [SEG_W-1:0] SEG_MINUS = 7'b1000000;
  localparam logic [SEG_W-1:0] SEG_OFF   = 7'b0000000;

  // Latched display content; dig[0]=units, dig[1]=tens, dig[2]=hundreds.
  typedef struct packed {
    logic                             sign;
    logic [NUM_DIGITS-1:0][BCD_W-1:0] dig;
  } disp_t;

endpackage

// File: rtl/bcd_to_seg7.sv
// One BCD code to an active-high 7-segment pattern. Codes 10..15 light
// nothing and raise invalid.
module bcd_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] seg,
  output logic       invalid
);

  // Standard digit table; anything past 9 is dark and flagged.
  always_comb begin
    invalid = 1'b0;
    seg     = SEG_OFF;
    case (code)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: begin
        seg     = SEG_OFF;
        invalid = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/signed_digits_7seg_scan.sv
// Latches sign/hundreds/tens/units on load and time-multiplexes them onto a
// 4-digit 7-segment display with leading-zero blanking and a '-' sign digit.
module signed_digits_7seg_scan #(
  parameter int REFRESH_DIV = 50000,
  parameter bit SEG_ACT_LOW = 1'b1,
  parameter bit AN_ACT_LOW  = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       load,
  input  logic       sign_in,
  input  logic [3:0] hund_in,
  input  logic [3:0] tens_in,
  input  logic [3:0] units_in,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       bcd_err
);

  import seg7_pkg::*;

  localparam int               PW          = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0]    PRESC_TC    = PW'(REFRESH_DIV - 1);
  localparam logic [NUM_AN-1:0] AN_PIN_OFF = AN_ACT_LOW  ? {NUM_AN{1'b1}} : {NUM_AN{1'b0}};
  localparam logic [SEG_W-1:0] SEG_PIN_OFF = SEG_ACT_LOW ? {SEG_W{1'b1}}  : {SEG_W{1'b0}};

  disp_t                              disp_q, disp_d;
  logic  [PW-1:0]                     presc_q, presc_d;
  idx_e                               idx_q, idx_d;
  logic  [NUM_AN-1:0]                 an_q, an_d;
  logic  [SEG_W-1:0]                  seg_q, seg_d;

  logic  [NUM_DIGITS-1:0][SEG_W-1:0]  dig_seg;
  logic  [NUM_DIGITS-1:0]             dig_inv;

  logic                               show;
  logic  [SEG_W-1:0]                  pat;
  logic  [NUM_AN-1:0]                 an_hot;

  // One decoder per numeric lane, all fed from the latched digits.
  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dec
    bcd_to_seg7 u_dec (
      .code    (disp_q.dig[i]),
      .seg     (dig_seg[i]),
      .invalid (dig_inv[i])
    );
  end

  // Capture on load; otherwise hold the last frame.
  always_comb begin
    disp_d = disp_q;
    if (load) begin
      disp_d.sign = sign_in;
      disp_d.dig  = {hund_in, tens_in, units_in};
    end
  end

  // Prescaler and scan index: parked at UNITS/0 while disabled so the first
  // slot after enable gets a full period.
  always_comb begin
    presc_d = presc_q;
    idx_d   = idx_q;
    if (!enable) begin
      presc_d = '0;
      idx_d   = IDX_UNITS;
    end else if (presc_q == PRESC_TC) begin
      presc_d = '0;
      idx_d   = idx_e'(idx_q + 2'd1);
    end else begin
      presc_d = presc_q + PW'(1);
    end
  end

  // Blanking mux and pin polarity for the current slot. Invalid codes keep
  // the anode on but light nothing (decoder already returns SEG_OFF).
  always_comb begin
    show = 1'b1;
    pat  = dig_seg[0];
    case (idx_q)
      IDX_UNITS: begin
        show = 1'b1;
        pat  = dig_seg[0];
      end
      IDX_TENS: begin
        show = (disp_q.dig[2] != 4'd0) || (disp_q.dig[1] != 4'd0);
        pat  = dig_seg[1];
      end
      IDX_HUNDREDS: begin
        show = (disp_q.dig[2] != 4'd0);
        pat  = dig_seg[2];
      end
      default: begin
        show = disp_q.sign;
        pat  = SEG_MINUS;
      end
    endcase

    an_hot = 4'b0001 << idx_q;
    an_d   = AN_PIN_OFF;
    seg_d  = SEG_PIN_OFF;
    if (enable && show) begin
      an_d  = AN_ACT_LOW  ? ~an_hot : an_hot;
      seg_d = SEG_ACT_LOW ? ~pat    : pat;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      disp_q  <= '0;
      presc_q <= '0;
      idx_q   <= IDX_UNITS;
      an_q    <= AN_PIN_OFF;
      seg_q   <= SEG_PIN_OFF;
    end else begin
      disp_q  <= disp_d;
      presc_q <= presc_d;
      idx_q   <= idx_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  // Error follows the latched digits, so it is set by the capturing edge and
  // stays until a load with all three digits valid.
  assign bcd_err = |dig_inv;

endmodule
